lcd_timer_counter: RTL and testbench
====================================

Name: lcd_timer_counter

Overview:
- Character-LCD (HD44780-compatible, 8-bit bus, write-only) controller driven by a one-shot request interface.
- Each accepted request runs one function: init sequence, set cursor, raw command, or data write.
- Generates E/RS/RW/DATA timing from an internal cycle counter scaled by FREQ.
- Pulses o_done_lcd when finished; sits between the system FSM and the board LCD pins.

Parameters:
- SIZE_DATA, 8, LCD data bus / i_data width.
- SIZE_FUNC, 4, function-select width.
- FREQ, 50_000_000, clock frequency in Hz; all delays are derived from it.

Ports:
- i_clk  in  1  clock, single domain.
- i_rst  in  1  synchronous, active-high reset.
- i_en_lcd  in  1  request strobe; sampled only in IDLE.
- i_on_lcd  in  1  requested LCD power state.
- i_lcd_blon  in  1  requested backlight state.
- i_data  in  SIZE_DATA  cursor position or command/data byte.
- i_func  in  SIZE_FUNC  0=init, 1=set cursor, 2=command, 3=data.
- o_LCD_DATA  out  SIZE_DATA  LCD data bus.
- o_LCD_E  out  1  enable strobe.
- o_LCD_RW  out  1  read/write; held 0 (write only).
- o_LCD_RS  out  1  0=instruction, 1=data.
- o_LCD_ON  out  1  LCD power.
- o_LCD_BLON  out  1  backlight.
- o_done_lcd  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- o_LCD_ON / o_LCD_BLON are registers loaded from i_on_lcd / i_lcd_blon only when a request is accepted. Changes to those inputs while idle have no effect until the next request.
- Acceptance: IDLE and i_en_lcd=1 at a clock edge; latch i_func and i_data. i_en_lcd while busy is ignored.
- Delay constants, in cycles:
  - T_SET = FREQ/10_000_000 (100 ns).
  - T_PW = FREQ/2_000_000 (500 ns).
  - T_SHORT = FREQ/25_000 (40 us).
  - T_LONG = FREQ/625 (1.6 ms).
  - T_PWR = FREQ/1000*15 (15 ms).
  - Each is at least 1.
- Byte write sequence:
  - SETUP: drive DATA and RS with E=0 for T_SET.
  - PULSE: E=1 for T_PW.
  - HOLD: E=0 with DATA/RS held for T_SET.
  - WAIT: T_SHORT, or T_LONG when the byte is an instruction equal to 0x01 or 0x02.
- func 0 (init): POWERUP wait T_PWR, then instructions 0x38, 0x0C, 0x01, 0x06 in order.
- func 1 (set cursor): one instruction 0x80 | (i_data[4] ? 0x40 : 0x00) | i_data[3:0]. i_data[4] is the row, [3:0] the column; other bits are ignored.
- func 2 (command): instruction byte i_data, RS=0.
- func 3 (data): byte i_data, RS=1.
- func 4..15: no bus activity; done pulses the cycle after acceptance.
- FSM states: IDLE, POWERUP, SETUP, PULSE, HOLD, WAIT, NEXT (advance init index), DONE.
- DONE asserts o_done_lcd for exactly one cycle, then returns to IDLE.
- o_LCD_DATA and o_LCD_RS keep the last driven value while idle.
- Reset mid-operation aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro LCD_FAST_SIM_EN.
- Defined: every delay constant is divided by 1000 (floor, minimum 1), for fast simulation.
- Undefined: real-time delays as above.
- Sequencing and outputs are otherwise identical.

Decomposition:
- Package lcd_pkg holds:
  - function code constants FN_INIT, FN_CURSOR, FN_CMD, FN_DATA;
  - FSM state enum;
  - instruction constants 0x38, 0x0C, 0x01, 0x06, 0x80, 0x40;
  - delay divisor localparams.
- One sub-module, lcd_delay_counter: load value, count down, assert expired.

Test Plan:
- Reset, then i_on_lcd=i_lcd_blon=0 for 10 cycles, then 1 for 10 cycles with no request -> o_LCD_ON=o_LCD_BLON=0 throughout; E=0, done=0.
- func=0 with i_on_lcd=i_lcd_blon=1 -> T_PWR idle, four E pulses carrying 0x38/0x0C/0x01/0x06 with RS=0. Each E high for T_PW cycles; T_LONG wait after 0x01. Single done pulse; ON=BLON=1.
- func=1 with i_data 0x00/0x05/0x10/0x15 -> one pulse each with DATA 0x80/0x85/0xC0/0xC5, RS=0, RW=0, then done.
- func=2 with 0x01, 0x02, 0x06 -> RS=0, DATA equals i_data. Done after T_LONG, T_LONG and T_SHORT waits respectively.
- func=3 with 0x29, 0x30 -> RS=1, DATA 0x29 then 0x30, done after T_SHORT.
- i_en_lcd re-asserted mid-operation, then reset mid-operation -> extra request ignored; reset returns all outputs to 0 with no done pulse.

Source files
------------

// File: rtl/lcd_timer_counter_pkg.sv
// Shared constants, state encoding and delay helpers for the HD44780 write controller.
// Build option: define LCD_FAST_SIM_EN to shrink every delay by 1000x for simulation.
package lcd_pkg;

    localparam logic [3:0] FN_INIT   = 4'd0;
    localparam logic [3:0] FN_CURSOR = 4'd1;
    localparam logic [3:0] FN_CMD    = 4'd2;
    localparam logic [3:0] FN_DATA   = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POWERUP,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } lcd_state_t;

    localparam logic [7:0] INS_FUNC_SET = 8'h38;
    localparam logic [7:0] INS_DISP_ON  = 8'h0C;
    localparam logic [7:0] INS_CLEAR    = 8'h01;
    localparam logic [7:0] INS_HOME     = 8'h02;
    localparam logic [7:0] INS_ENTRY    = 8'h06;
    localparam logic [7:0] INS_DDRAM    = 8'h80;
    localparam logic [7:0] DDRAM_ROW2   = 8'h40;

    localparam int DIV_SET      = 10_000_000;
    localparam int DIV_PW       = 2_000_000;
    localparam int DIV_SHORT    = 25_000;
    localparam int DIV_LONG     = 625;
    localparam int DIV_PWR      = 1000;
    localparam int MUL_PWR      = 15;
    localparam int FAST_SIM_DIV = 1000;

    // Cycle count for a delay of mul/div seconds at freq Hz, never below one cycle.
    function automatic int delay_cycles(int freq, int div, int mul);
        int t;
        t = (freq / div) * mul;
`ifdef LCD_FAST_SIM_EN
        t = t / FAST_SIM_DIV;
`endif
        return (t < 1) ? 1 : t;
    endfunction

    function automatic logic [7:0] init_byte(logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = INS_FUNC_SET;
            2'd1:    b = INS_DISP_ON;
            2'd2:    b = INS_CLEAR;
            default: b = INS_ENTRY;
        endcase
        return b;
    endfunction

    // pos[4] selects the row, pos[3:0] the column.
    function automatic logic [7:0] cursor_byte(logic [4:0] pos);
        return INS_DDRAM | (pos[4] ? DDRAM_ROW2 : 8'h00) | {4'h0, pos[3:0]};
    endfunction

endpackage

// File: rtl/lcd_timer_counter_if.sv
// Request side of the LCD controller: one-shot request strobe plus completion pulse.
interface lcd_timer_counter_if #(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_FUNC = 4
);
    // en_lcd is a single-cycle request; it is taken only while the controller is idle
    // (no ready: a strobe while busy is dropped). done_lcd pulses once per taken request.
    logic                 en_lcd;
    logic                 on_lcd;
    logic                 lcd_blon;
    logic [SIZE_DATA-1:0] data;
    logic [SIZE_FUNC-1:0] func;
    logic                 done_lcd;

    modport master (output en_lcd, on_lcd, lcd_blon, data, func, input done_lcd);
    modport slave  (input en_lcd, on_lcd, lcd_blon, data, func, output done_lcd);
endinterface

// File: rtl/lcd_timer_counter_delay_counter.sv
// Down counter: load a value, decrement to zero, report expired while at zero.
module lcd_delay_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/lcd_timer_counter.sv
// HD44780 8-bit write-only controller: init, set cursor, command and data requests.
// Build option: LCD_FAST_SIM_EN (see lcd_pkg) scales all delays down for simulation.
module lcd_timer_counter
    import lcd_pkg::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_FUNC = 4,
    parameter int FREQ      = 50_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lcd_timer_counter_if.slave   req,
    output logic [SIZE_DATA-1:0] o_LCD_DATA,
    output logic                 o_LCD_E,
    output logic                 o_LCD_RW,
    output logic                 o_LCD_RS,
    output logic                 o_LCD_ON,
    output logic                 o_LCD_BLON,
    output lcd_state_t           dbg_state
);
    localparam int T_SET   = delay_cycles(FREQ, DIV_SET, 1);
    localparam int T_PW    = delay_cycles(FREQ, DIV_PW, 1);
    localparam int T_SHORT = delay_cycles(FREQ, DIV_SHORT, 1);
    localparam int T_LONG  = delay_cycles(FREQ, DIV_LONG, 1);
    localparam int T_PWR   = delay_cycles(FREQ, DIV_PWR, MUL_PWR);

    lcd_state_t           state_q, state_d;
    logic [SIZE_FUNC-1:0] func_q, func_d;
    logic [1:0]           idx_q, idx_d;
    logic [SIZE_DATA-1:0] lcd_data_q, lcd_data_d;
    logic                 rs_q, rs_d;
    logic                 on_q, on_d;
    logic                 blon_q, blon_d;
    logic                 load;
    logic [31:0]          load_val;
    logic                 expired;
    logic                 long_wait;

    lcd_delay_counter #(.W(32)) u_delay (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    // Clear display and return home need the long execution time.
    assign long_wait = !rs_q && ((lcd_data_q == SIZE_DATA'(INS_CLEAR)) ||
                                 (lcd_data_q == SIZE_DATA'(INS_HOME)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            func_q     <= '0;
            idx_q      <= '0;
            lcd_data_q <= '0;
            rs_q       <= 1'b0;
            on_q       <= 1'b0;
            blon_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            func_q     <= func_d;
            idx_q      <= idx_d;
            lcd_data_q <= lcd_data_d;
            rs_q       <= rs_d;
            on_q       <= on_d;
            blon_q     <= blon_d;
        end
    end

    // Each timed state loads (delay - 1) on entry, so it lasts exactly delay cycles.
    always_comb begin
        state_d    = state_q;
        func_d     = func_q;
        idx_d      = idx_q;
        lcd_data_d = lcd_data_q;
        rs_d       = rs_q;
        on_d       = on_q;
        blon_d     = blon_q;
        load       = 1'b0;
        load_val   = '0;
        case (state_q)
            ST_IDLE: begin
                if (req.en_lcd) begin
                    func_d = req.func;
                    on_d   = req.on_lcd;
                    blon_d = req.lcd_blon;
                    idx_d  = '0;
                    case (req.func)
                        SIZE_FUNC'(FN_INIT): begin
                            state_d  = ST_POWERUP;
                            load     = 1'b1;
                            load_val = 32'(T_PWR - 1);
                        end
                        SIZE_FUNC'(FN_CURSOR): begin
                            state_d    = ST_SETUP;
                            lcd_data_d = SIZE_DATA'(cursor_byte(req.data[4:0]));
                            rs_d       = 1'b0;
                            load       = 1'b1;
                            load_val   = 32'(T_SET - 1);
                        end
                        SIZE_FUNC'(FN_CMD): begin
                            state_d    = ST_SETUP;
                            lcd_data_d = req.data;
                            rs_d       = 1'b0;
                            load       = 1'b1;
                            load_val   = 32'(T_SET - 1);
                        end
                        SIZE_FUNC'(FN_DATA): begin
                            state_d    = ST_SETUP;
                            lcd_data_d = req.data;
                            rs_d       = 1'b1;
                            load       = 1'b1;
                            load_val   = 32'(T_SET - 1);
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_POWERUP: begin
                if (expired) begin
                    state_d    = ST_SETUP;
                    lcd_data_d = SIZE_DATA'(init_byte(2'd0));
                    rs_d       = 1'b0;
                    load       = 1'b1;
                    load_val   = 32'(T_SET - 1);
                end
            end
            ST_SETUP: begin
                if (expired) begin
                    state_d  = ST_PULSE;
                    load     = 1'b1;
                    load_val = 32'(T_PW - 1);
                end
            end
            ST_PULSE: begin
                if (expired) begin
                    state_d  = ST_HOLD;
                    load     = 1'b1;
                    load_val = 32'(T_SET - 1);
                end
            end
            ST_HOLD: begin
                if (expired) begin
                    state_d  = ST_WAIT;
                    load     = 1'b1;
                    load_val = long_wait ? 32'(T_LONG - 1) : 32'(T_SHORT - 1);
                end
            end
            ST_WAIT: begin
                if (expired) begin
                    state_d = (func_q == SIZE_FUNC'(FN_INIT)) ? ST_NEXT : ST_DONE;
                end
            end
            ST_NEXT: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_SETUP;
                    idx_d      = idx_q + 2'd1;
                    lcd_data_d = SIZE_DATA'(init_byte(idx_q + 2'd1));
                    rs_d       = 1'b0;
                    load       = 1'b1;
                    load_val   = 32'(T_SET - 1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_LCD_DATA   = lcd_data_q;
    assign o_LCD_RS     = rs_q;
    assign o_LCD_RW     = 1'b0;
    assign o_LCD_E      = (state_q == ST_PULSE);
    assign o_LCD_ON     = on_q;
    assign o_LCD_BLON   = blon_q;
    assign req.done_lcd = (state_q == ST_DONE);
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_lcd_timer_counter.sv
// Bench for lcd_timer_counter: table of single requests, init and abort sequences.
module tb_lcd_timer_counter;
    import lcd_pkg::*;

    localparam int FREQ = 2_000_000;
    localparam int W    = 25;  // {gap[15:0], rs, data[7:0]}

    typedef struct {
        logic [3:0] func;
        logic [7:0] data;
        logic       on;
        logic       blon;
        logic       has_byte;
        logic       rs;
        logic [7:0] byte_exp;
        int         wait_cyc;
    } vec_t;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] o_LCD_DATA;
    logic       o_LCD_E, o_LCD_RW, o_LCD_RS, o_LCD_ON, o_LCD_BLON;
    lcd_state_t dbg_state;

    lcd_timer_counter_if #(.SIZE_DATA(8), .SIZE_FUNC(4)) req_if ();

    lcd_timer_counter #(.SIZE_DATA(8), .SIZE_FUNC(4), .FREQ(FREQ)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .req        (req_if.slave),
        .o_LCD_DATA (o_LCD_DATA),
        .o_LCD_E    (o_LCD_E),
        .o_LCD_RW   (o_LCD_RW),
        .o_LCD_RS   (o_LCD_RS),
        .o_LCD_ON   (o_LCD_ON),
        .o_LCD_BLON (o_LCD_BLON),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int t_set, t_pw, t_short, t_long, t_pwr;

    function automatic int bench_delay(int div, int mul);
        int t;
        t = FREQ / div * mul;
`ifdef LCD_FAST_SIM_EN
        t = t / 1000;
`endif
        if (t < 1) t = 1;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    // scoreboard: every rising E edge is matched against the expected queue
    int         cyc = 0;
    int         last_rise = 0;
    int         e_width = 0;
    logic       e_prev = 1'b0;
    logic [7:0] rise_data;
    logic       rise_rs;
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (o_LCD_E && !e_prev) begin
                e_width   = 1;
                rise_data = o_LCD_DATA;
                rise_rs   = o_LCD_RS;
                check("pulse_rw", {31'd0, o_LCD_RW}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse got rs=%0b data=%0h want no pulse", o_LCD_RS, o_LCD_DATA);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_rs", {31'd0, o_LCD_RS}, {31'd0, e[8]});
                    check("pulse_data", {24'd0, o_LCD_DATA}, {24'd0, e[7:0]});
                    if (e[24:9] != 16'd0) check("pulse_gap", cyc - last_rise, {16'd0, e[24:9]});
                end
                last_rise = cyc;
            end else if (o_LCD_E) begin
                e_width++;
            end else if (e_prev) begin
                check("e_width", e_width, t_pw);
                check("hold_data", {24'd0, o_LCD_DATA}, {24'd0, rise_data});
                check("hold_rs", {31'd0, o_LCD_RS}, {31'd0, rise_rs});
            end
            e_prev = o_LCD_E;
        end
    end

    // driver tasks
    task automatic do_req(input logic [3:0] f, input logic [7:0] d, input logic on, input logic blon);
        @(negedge i_clk);
        req_if.func     = f;
        req_if.data     = d;
        req_if.on_lcd   = on;
        req_if.lcd_blon = blon;
        req_if.en_lcd   = 1'b1;
        @(posedge i_clk);
        #1;
        req_if.en_lcd   = 1'b0;
        req_if.data     = 8'($urandom_range(0, 255));
        req_if.on_lcd   = 1'($urandom_range(0, 1));
        req_if.lcd_blon = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int k;
        logic seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < exp_lat + 200) begin
            @(negedge i_clk);
            k++;
            if (req_if.done_lcd) seen = 1'b1;
        end
        check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        if (seen) check({name, "_latency"}, k, exp_lat);
        @(negedge i_clk);
        check({name, "_done_one_cycle"}, {31'd0, req_if.done_lcd}, 32'd0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] mk(input int gap, input logic rs, input logic [7:0] d);
        return {16'(gap), rs, d};
    endfunction

    vec_t vecs[13];

    initial begin
        int lat, cnt_done, cnt_e;
        t_set   = bench_delay(10_000_000, 1);
        t_pw    = bench_delay(2_000_000, 1);
        t_short = bench_delay(25_000, 1);
        t_long  = bench_delay(625, 1);
        t_pwr   = bench_delay(1000, 15);

        vecs[0]  = '{4'd1,  8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80, t_short};
        vecs[1]  = '{4'd1,  8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 8'h85, t_short};
        vecs[2]  = '{4'd1,  8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC0, t_short};
        vecs[3]  = '{4'd1,  8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC5, t_short};
        vecs[4]  = '{4'd1,  8'hF3, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, t_short};
        vecs[5]  = '{4'd2,  8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01, t_long};
        vecs[6]  = '{4'd2,  8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 8'h02, t_long};
        vecs[7]  = '{4'd2,  8'h06, 1'b1, 1'b0, 1'b1, 1'b0, 8'h06, t_short};
        vecs[8]  = '{4'd3,  8'h29, 1'b1, 1'b1, 1'b1, 1'b1, 8'h29, t_short};
        vecs[9]  = '{4'd3,  8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30, t_short};
        vecs[10] = '{4'd3,  8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, t_short};
        vecs[11] = '{4'd5,  8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0};
        vecs[12] = '{4'd15, 8'h38, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0};

        req_if.en_lcd = 1'b0; req_if.on_lcd = 1'b0; req_if.lcd_blon = 1'b0;
        req_if.data = 8'h00; req_if.func = 4'h0;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", {21'd0, o_LCD_DATA, o_LCD_E, o_LCD_RW, o_LCD_RS, o_LCD_ON, o_LCD_BLON, req_if.done_lcd}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        i_rst = 1'b0;

        // idle: power/backlight inputs alone must not reach the outputs
        for (int i = 0; i < 20; i++) begin
            req_if.on_lcd   = (i >= 10);
            req_if.lcd_blon = (i >= 10);
            req_if.data     = 8'($urandom_range(0, 255));
            req_if.func     = 4'($urandom_range(0, 15));
            @(negedge i_clk);
            check("idle_quiet", {28'd0, o_LCD_ON, o_LCD_BLON, o_LCD_E, req_if.done_lcd}, 32'd0);
        end

        // init sequence
        exp_q.push_back(mk(0, 1'b0, 8'h38));
        exp_q.push_back(mk(t_pw + t_set + t_short + 1 + t_set, 1'b0, 8'h0C));
        exp_q.push_back(mk(t_pw + t_set + t_short + 1 + t_set, 1'b0, 8'h01));
        exp_q.push_back(mk(t_pw + t_set + t_long + 1 + t_set, 1'b0, 8'h06));
        do_req(4'd0, 8'h00, 1'b1, 1'b1);
        wait_done(t_pwr + 4 * (2 * t_set + t_pw) + 3 * t_short + t_long + 4 + 1, "init");
        check("init_on_blon", {30'd0, o_LCD_ON, o_LCD_BLON}, 32'd3);

        // single-request table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].has_byte) exp_q.push_back(mk(0, vecs[i].rs, vecs[i].byte_exp));
            lat = vecs[i].has_byte ? (2 * t_set + t_pw + vecs[i].wait_cyc + 1) : 1;
            do_req(vecs[i].func, vecs[i].data, vecs[i].on, vecs[i].blon);
            wait_done(lat, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_on_blon", i), {30'd0, o_LCD_ON, o_LCD_BLON}, {30'd0, vecs[i].on, vecs[i].blon});
        end

        // request while busy is dropped
        exp_q.push_back(mk(0, 1'b1, 8'h41));
        do_req(4'd3, 8'h41, 1'b0, 1'b1);
        repeat (4) @(negedge i_clk);
        req_if.func = 4'd2; req_if.data = 8'h01; req_if.on_lcd = 1'b1; req_if.lcd_blon = 1'b0;
        req_if.en_lcd = 1'b1;
        @(posedge i_clk);
        #1 req_if.en_lcd = 1'b0;
        wait_done(2 * t_set + t_pw + t_short + 1 - 4, "busy_ignore");
        cnt_done = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (req_if.done_lcd) cnt_done++;
        end
        check("busy_no_extra_done", cnt_done, 0);
        check("busy_on_blon", {30'd0, o_LCD_ON, o_LCD_BLON}, 32'd1);

        // reset in the middle of a long wait
        exp_q.push_back(mk(0, 1'b0, 8'h02));
        do_req(4'd2, 8'h02, 1'b1, 1'b1);
        repeat (10) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_outputs", {21'd0, o_LCD_DATA, o_LCD_E, o_LCD_RW, o_LCD_RS, o_LCD_ON, o_LCD_BLON, req_if.done_lcd}, 32'd0);
        check("abort_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        @(negedge i_clk);
        i_rst = 1'b0;
        cnt_done = 0;
        cnt_e = 0;
        repeat (t_long + 50) begin
            @(negedge i_clk);
            if (req_if.done_lcd) cnt_done++;
            if (o_LCD_E) cnt_e++;
        end
        check("abort_no_done", cnt_done, 0);
        check("abort_no_e", cnt_e, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
